// File: rtl/net_dr2l2_snack_route_pkg.sv
// ---------------------------------------------------------------------------
// net_dr2l2_snack_route_pkg
//   Shared types and constants for the directory -> L2 snack return path.
//   - NUM_L2_DEF : default number of L2 destinations (c0/c1 x l2i,l2d_0,l2d_1)
//   - L2ID_W     : width of the node-id field carried in every snack
//   - l2_nid_e   : node-id encoding of the L2 pipes
//   - I_drtol2_snack_type : snack payload
//   - snack_dest(): extracts the destination index from a snack
// ---------------------------------------------------------------------------
package net_dr2l2_snack_route_pkg;

  localparam int NUM_L2_DEF = 6;
  localparam int L2ID_W     = 4;

  // Node ids 6..15 are not L2 pipes in the 6-destination build; the router
  // counts and discards anything addressed to them.
  typedef enum logic [L2ID_W-1:0] {
    C0_L2I  = 4'd0,
    C0_L2D0 = 4'd1,
    C0_L2D1 = 4'd2,
    C1_L2I  = 4'd3,
    C1_L2D0 = 4'd4,
    C1_L2D1 = 4'd5
  } l2_nid_e;

  typedef struct packed {
    logic [L2ID_W-1:0] nid;
    logic [3:0]        cmd;
    logic [31:0]       addr;
    logic [7:0]        tag;
  } I_drtol2_snack_type;

  function automatic logic [L2ID_W-1:0] snack_dest(input I_drtol2_snack_type s);
    return s.nid;
  endfunction

endpackage

// File: rtl/net_dr2l2_snack_route_if.sv
// ---------------------------------------------------------------------------
// net_dr2l2_snack_route_if
//   Bundles the directory-side input stream and the per-L2 output streams.
//   Signals:
//     drtol2_snack_valid / drtol2_snack_retry / drtol2_snack : directory input
//     l2_snack_valid[NUM_L2] / l2_snack_retry[NUM_L2] / l2_snack[NUM_L2] :
//                                                      per-L2 outputs
//   Modports:
//     master : directory + L2 side (drives input stream and L2 retries)
//     slave  : the router
//
//   Handshake (every stream): a word transfers on a clock edge where
//   valid && !retry. Once valid is raised the sender keeps valid and payload
//   stable while retry is high. valid never depends combinationally on retry.
// ---------------------------------------------------------------------------
interface net_dr2l2_snack_route_if
  import net_dr2l2_snack_route_pkg::*;
#(
  parameter int NUM_L2 = NUM_L2_DEF
) ();

  logic               drtol2_snack_valid;
  logic               drtol2_snack_retry;
  I_drtol2_snack_type drtol2_snack;

  logic [NUM_L2-1:0]  l2_snack_valid;
  logic [NUM_L2-1:0]  l2_snack_retry;
  I_drtol2_snack_type l2_snack [NUM_L2];

  modport master (
    output drtol2_snack_valid,
    output drtol2_snack,
    input  drtol2_snack_retry,
    input  l2_snack_valid,
    input  l2_snack,
    output l2_snack_retry
  );

  modport slave (
    input  drtol2_snack_valid,
    input  drtol2_snack,
    output drtol2_snack_retry,
    output l2_snack_valid,
    output l2_snack,
    input  l2_snack_retry
  );

endinterface

// File: rtl/net_dr2l2_snack_route_fifo.sv
// ---------------------------------------------------------------------------
// net_dr2l2_snack_route_fifo
//   Per-destination snack FIFO with valid/retry on both sides.
//   Ports:
//     clk, rst_n            : clock, asynchronous active-low reset
//     in_valid/in_retry     : write side; in_retry = in_valid && full
//     in_data               : snack to enqueue
//     out_valid/out_retry   : read side; out_valid = !empty
//     out_data              : head entry, read straight from storage flops
//   Pointers carry one extra wrap bit so full and empty are distinguishable
//   when the index bits match. full/empty come only from registered pointers,
//   so a pop this cycle frees a slot for the writer only on the next cycle.
// ---------------------------------------------------------------------------
module net_dr2l2_snack_route_fifo
  import net_dr2l2_snack_route_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_retry,
  input  I_drtol2_snack_type in_data,
  output logic               out_valid,
  input  logic               out_retry,
  output I_drtol2_snack_type out_data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;
  I_drtol2_snack_type mem_q [DEPTH];
  I_drtol2_snack_type mem_d [DEPTH];

  logic           empty;
  logic           full;
  logic           push;
  logic           pop;
  logic [PTR_W:0] occ;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  assign in_retry  = in_valid && full;
  assign push      = in_valid && !full;
  assign out_valid = !empty;
  assign pop       = out_valid && !out_retry;
  assign out_data  = mem_q[rd_ptr_q[PTR_W-1:0]];

  // Wrap-bit subtraction gives the true occupancy modulo 2*DEPTH.
  assign occ = wr_ptr_q - rd_ptr_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = in_data;
      wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

  // Occupancy can never exceed the depth (no overflow, and an underflow
  // would wrap to a large value and trip the same check).
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (occ <= (PTR_W+1)'(DEPTH));
    end
  end

endmodule

// File: rtl/net_dr2l2_snack_route.sv
// ---------------------------------------------------------------------------
// net_dr2l2_snack_route
//   Routes the single directory snack stream to one of NUM_L2 L2 pipes by the
//   node-id in each snack. Each destination owns a FIFO_D-deep FIFO, so a
//   stalled L2 only back-pressures the directory when a snack for that L2
//   arrives while its FIFO is full.
//   Ports:
//     clk       : clock
//     reset     : asynchronous active-low reset
//     bus       : slave side of net_dr2l2_snack_route_if (input stream and
//                 per-L2 output streams)
//     drop_cnt  : saturating count of snacks dropped for a bad node-id
//     drop_err  : sticky flag, set by any bad node-id snack until reset
//   Input retry depends only on the input node-id and registered FIFO state;
//   there is no path from any l2_snack_retry to drtol2_snack_retry.
// ---------------------------------------------------------------------------
module net_dr2l2_snack_route
  import net_dr2l2_snack_route_pkg::*;
#(
  parameter int NUM_L2 = NUM_L2_DEF,
  parameter int FIFO_D = 2,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  net_dr2l2_snack_route_if.slave   bus,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic                     drop_err
);

  localparam logic [L2ID_W-1:0] NUM_L2_ID = L2ID_W'(NUM_L2);

  logic [L2ID_W-1:0]  dest;
  logic               dest_ok;
  logic               drop_now;
  logic [NUM_L2-1:0]  push_req;
  logic [NUM_L2-1:0]  fifo_in_retry;
  logic [NUM_L2-1:0]  l2_valid;
  I_drtol2_snack_type l2_data [NUM_L2];

  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic               drop_err_q, drop_err_d;

  assign dest    = snack_dest(bus.drtol2_snack);
  assign dest_ok = (dest < NUM_L2_ID);

  // Bad node-ids are always accepted (never retried) and simply discarded.
  assign drop_now = bus.drtol2_snack_valid && !dest_ok;

  for (genvar i = 0; i < NUM_L2; i++) begin : g_dest
    assign push_req[i] = bus.drtol2_snack_valid && dest_ok &&
                         (dest == L2ID_W'(i));

    net_dr2l2_snack_route_fifo #(
      .DEPTH (FIFO_D)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (reset),
      .in_valid  (push_req[i]),
      .in_retry  (fifo_in_retry[i]),
      .in_data   (bus.drtol2_snack),
      .out_valid (l2_valid[i]),
      .out_retry (bus.l2_snack_retry[i]),
      .out_data  (l2_data[i])
    );
  end

  // At most one push_req bit is set, so the OR is the retry of the one
  // FIFO the current snack targets.
  assign bus.drtol2_snack_retry = |fifo_in_retry;
  assign bus.l2_snack_valid     = l2_valid;
  assign bus.l2_snack           = l2_data;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    drop_err_d = drop_err_q;
    if (drop_now) begin
      drop_err_d = 1'b1;
      if (drop_cnt_q != {CNT_W{1'b1}}) begin
        drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt_q <= '0;
      drop_err_q <= 1'b0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      drop_err_q <= drop_err_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
  assign drop_err = drop_err_q;

endmodule

// File: tb/tb_net_dr2l2_snack_route.sv
// ---------------------------------------------------------------------------
// tb_net_dr2l2_snack_route
//   Directed bench for net_dr2l2_snack_route. Inputs change 1 ns after the
//   rising edge; outputs are sampled 3 ns after it (combinational retry) or
//   1 ns after it (registered outputs). A per-destination expected queue
//   tracks what each L2 port must present.
// ---------------------------------------------------------------------------
module tb_net_dr2l2_snack_route;
  import net_dr2l2_snack_route_pkg::*;

  localparam int NUM_L2 = 6;
  localparam int FIFO_D = 2;
  localparam int CNT_W  = 8;
  localparam int SW     = $bits(I_drtol2_snack_type);

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  net_dr2l2_snack_route_if #(.NUM_L2(NUM_L2)) bus ();
  logic [CNT_W-1:0] drop_cnt;
  logic             drop_err;

  net_dr2l2_snack_route #(
    .NUM_L2 (NUM_L2),
    .FIFO_D (FIFO_D),
    .CNT_W  (CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .drop_cnt (drop_cnt),
    .drop_err (drop_err)
  );

  // ---------------- scoreboard ----------------
  int             n_vec = 0;
  int             n_err = 0;
  logic [SW-1:0]  exp_q [NUM_L2][$];
  int             exp_drop = 0;
  bit             exp_err  = 1'b0;
  logic           last_retry;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic I_drtol2_snack_type mk(input logic [3:0] nid, input logic [7:0] tag);
    I_drtol2_snack_type s;
    s.nid  = nid;
    s.cmd  = 4'h3;
    s.addr = {16'hBEEF, 4'h0, nid, tag};
    s.tag  = tag;
    return s;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic v, input logic [3:0] nid, input logic [7:0] tag);
    bus.drtol2_snack_valid = v;
    bus.drtol2_snack       = mk(nid, tag);
  endtask

  // One clock with inputs already applied: check comb retry and all L2
  // outputs against the model, advance the model, then check the counters.
  task automatic cycle(output bit acc);
    int                d;
    bit                good;
    logic              exp_retry;
    logic [NUM_L2-1:0] exp_v;
    #2;
    d    = int'(bus.drtol2_snack.nid);
    good = (d < NUM_L2);
    exp_retry = bus.drtol2_snack_valid && good &&
                (exp_q[good ? d : 0].size() == FIFO_D);
    last_retry = bus.drtol2_snack_retry;
    chk("in_retry", 64'(bus.drtol2_snack_retry), 64'(exp_retry));
    for (int i = 0; i < NUM_L2; i++) exp_v[i] = (exp_q[i].size() != 0);
    chk("l2_valid", 64'(bus.l2_snack_valid), 64'(exp_v));
    for (int i = 0; i < NUM_L2; i++) begin
      if (exp_v[i]) chk($sformatf("l2_snack[%0d]", i), 64'(bus.l2_snack[i]), 64'(exp_q[i][0]));
    end
    acc = bus.drtol2_snack_valid && !exp_retry;
    for (int i = 0; i < NUM_L2; i++) begin
      if (exp_v[i] && !bus.l2_snack_retry[i]) void'(exp_q[i].pop_front());
    end
    if (acc && good) begin
      exp_q[d].push_back(bus.drtol2_snack);
    end else if (acc) begin
      exp_err = 1'b1;
      if (exp_drop < 255) exp_drop++;
    end
    @(posedge clk);
    #1;
    chk("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
    chk("drop_err", 64'(drop_err), 64'(exp_err));
  endtask

  task automatic drain(input int max_cycles);
    bit acc;
    int left;
    int n;
    send(1'b0, 4'd0, 8'h00);
    bus.l2_snack_retry = '0;
    n = 0;
    left = 0;
    for (int i = 0; i < NUM_L2; i++) left += exp_q[i].size();
    while (left != 0 && n < max_cycles) begin
      cycle(acc);
      n++;
      left = 0;
      for (int i = 0; i < NUM_L2; i++) left += exp_q[i].size();
    end
    chk("drain_left", 64'(left), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit acc;
    int sent;
    int guard;

    // Reset held with a valid snack on the input.
    bus.l2_snack_retry = '0;
    send(1'b1, 4'd2, 8'h11);
    @(posedge clk); #1;
    repeat (3) begin @(posedge clk); #1; end
    chk("rst_l2_valid", 64'(bus.l2_snack_valid), 64'd0);
    chk("rst_in_retry", 64'(bus.drtol2_snack_retry), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("rst_drop_err", 64'(drop_err), 64'd0);

    send(1'b0, 4'd2, 8'h11);
    reset = 1'b1;
    cycle(acc);                      // nothing was written during reset
    send(1'b1, 4'd2, 8'h21);
    cycle(acc);
    send(1'b0, 4'd0, 8'h00);
    chk("lat1_valid", 64'(bus.l2_snack_valid), 64'(6'b000100));
    chk("lat1_payload", 64'(bus.l2_snack[2]), 64'(mk(4'd2, 8'h21)));
    drain(4);

    // Per-destination blocking: L2D0 of c0 stalled, c1 L2D0 still flows.
    bus.l2_snack_retry = 6'b000010;
    send(1'b1, 4'd1, 8'h31); cycle(acc);
    send(1'b1, 4'd1, 8'h32); cycle(acc);
    send(1'b1, 4'd4, 8'h41); cycle(acc);
    chk("blk_valid_after_d", 64'(bus.l2_snack_valid), 64'(6'b010010));
    send(1'b1, 4'd1, 8'h33); cycle(acc);
    chk("blk_third_retry", 64'(last_retry), 64'd1);
    cycle(acc);
    chk("blk_third_retry2", 64'(last_retry), 64'd1);
    chk("blk_valid_after_pop4", 64'(bus.l2_snack_valid), 64'(6'b000010));
    bus.l2_snack_retry = 6'b000000;
    cycle(acc);
    chk("blk_retry_full_reg", 64'(last_retry), 64'd1);
    cycle(acc);
    chk("blk_third_accept", 64'(last_retry), 64'd0);
    drain(6);

    // Ordering / pointer wrap: 20 snacks to c0 L2I with random stalls.
    sent  = 0;
    guard = 0;
    while (sent < 20 && guard < 300) begin
      send(1'b1, 4'd0, 8'h50 + 8'(sent));
      bus.l2_snack_retry = 6'($urandom_range(0, 1));
      cycle(acc);
      if (acc) sent++;
      guard++;
    end
    chk("ord_sent", 64'(sent), 64'd20);
    drain(10);

    // FIFO 3 full; its L2 retry drops in the same cycle a new snack arrives.
    bus.l2_snack_retry = 6'b001000;
    send(1'b1, 4'd3, 8'h61); cycle(acc);
    send(1'b1, 4'd3, 8'h62); cycle(acc);
    chk("full_valid", 64'(bus.l2_snack_valid), 64'(6'b001000));
    send(1'b1, 4'd3, 8'h63);
    bus.l2_snack_retry = 6'b000000;
    cycle(acc);
    chk("full_pp_retry", 64'(last_retry), 64'd1);
    cycle(acc);
    chk("full_pp_accept", 64'(last_retry), 64'd0);
    drain(6);

    // Bad node-id: 300 snacks to nid 7.
    for (int k = 0; k < 300; k++) begin
      send(1'b1, 4'd7, 8'(k));
      cycle(acc);
    end
    chk("bad_drop_sat", 64'(drop_cnt), 64'd255);
    chk("bad_drop_err", 64'(drop_err), 64'd1);
    chk("bad_no_valid", 64'(bus.l2_snack_valid), 64'd0);
    send(1'b0, 4'd0, 8'h00);
    repeat (3) cycle(acc);
    chk("bad_err_sticky", 64'(drop_err), 64'd1);

    // Reset with two snacks queued for c1 L2D1.
    bus.l2_snack_retry = 6'b100000;
    send(1'b1, 4'd5, 8'h71); cycle(acc);
    send(1'b1, 4'd5, 8'h72); cycle(acc);
    send(1'b0, 4'd0, 8'h00);
    chk("mid_valid_before", 64'(bus.l2_snack_valid), 64'(6'b100000));
    reset = 1'b0;
    #1;
    chk("mid_async_valid", 64'(bus.l2_snack_valid), 64'd0);
    chk("mid_async_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("mid_async_drop_err", 64'(drop_err), 64'd0);
    for (int i = 0; i < NUM_L2; i++) exp_q[i].delete();
    exp_drop = 0;
    exp_err  = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    bus.l2_snack_retry = 6'b000000;
    cycle(acc);
    send(1'b1, 4'd5, 8'h73); cycle(acc);
    send(1'b0, 4'd0, 8'h00);
    chk("post_rst_valid", 64'(bus.l2_snack_valid), 64'(6'b100000));
    chk("post_rst_payload", 64'(bus.l2_snack[5]), 64'(mk(4'd5, 8'h73)));
    drain(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
